// File: rtl/inst_mem_pkg.sv
// Shared types and constants for the instruction memory fetch block.
package inst_mem_pkg;

  typedef enum logic [1:0] {
    FETCH,
    DRAIN,
    LOAD
  } fetch_state_t;

  typedef enum logic [1:0] {
    ERR_NONE     = 2'b00,
    ERR_MISALIGN = 2'b01,
    ERR_RANGE    = 2'b10
  } fetch_err_t;

  // addi x0,x0,0 -- returned in place of an instruction on any fetch error
  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

endpackage

// File: rtl/inst_mem_array.sv
// Byte-lane instruction storage: four independently enabled write lanes and
// a word-aligned synchronous read whose output register resets to zero.
module inst_mem_array #(
  parameter int DEPTH_BYTES = 1024,
  parameter int WORDS       = DEPTH_BYTES / 4,
  parameter int AW          = $clog2(WORDS)
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [31:0]   wdata,
  input  logic [3:0]    wbe,
  input  logic          re,
  input  logic [AW-1:0] raddr,
  output logic [31:0]   rdata
);

  for (genvar i = 0; i < 4; i++) begin : g_lane
    logic [7:0] lane_mem [WORDS];
    logic [7:0] lane_q;

    // Byte write for lane i.
    // NOTE: storage has no reset branch so it maps onto RAM and keeps the
    // loaded program across reset; only the read register is reset.
    always_ff @(posedge clk) begin
      if (we && wbe[i]) begin
        lane_mem[waddr] <= wdata[8*i +: 8];
      end
    end

    // Registered read for lane i; holds its value between reads.
    always_ff @(posedge clk) begin
      if (!reset_n) begin
        lane_q <= '0;
      end else if (re) begin
        lane_q <= lane_mem[raddr];
      end
    end

    assign rdata[8*i +: 8] = lane_q;
  end

endmodule

// File: rtl/inst_mem_fetch.sv
// Instruction memory with a valid/ready fetch port, 1-cycle registered
// response, alignment/range checking and a run-time program load port.
// Optional performance counters are enabled by defining INST_MEM_PERF_CNT_EN.
module inst_mem_fetch #(
  parameter int          ADDR_W      = 32,
  parameter int          DEPTH_BYTES = 1024,
  parameter logic [31:0] NOP_INSTR   = inst_mem_pkg::NOP_INSTR
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [ADDR_W-1:0] req_pc,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic [31:0]       resp_instr,
  output logic [1:0]        resp_err,
  input  logic              load_mode,
  input  logic              ld_valid,
  input  logic [ADDR_W-3:0] ld_addr,
  input  logic [31:0]       ld_data,
  input  logic [3:0]        ld_be,
  output logic              ld_err,
  output logic              in_load
`ifdef INST_MEM_PERF_CNT_EN
  ,
  output logic [31:0]       fetch_cnt,
  output logic [15:0]       err_cnt
`endif
);

  import inst_mem_pkg::*;

  localparam int WORDS = DEPTH_BYTES / 4;
  localparam int AW    = $clog2(WORDS);

  // One extra bit so the limits are representable whatever ADDR_W is.
  localparam logic [ADDR_W:0]   PC_LIMIT = (ADDR_W + 1)'(DEPTH_BYTES);
  localparam logic [ADDR_W-2:0] LD_LIMIT = (ADDR_W - 1)'(WORDS);

  fetch_state_t state;
  fetch_err_t   req_err;
  fetch_err_t   resp_err_q;
  logic         accept;
  logic         ld_oob;
  logic         mem_we;
  logic         mem_re;
  logic [31:0]  mem_rdata;

  // Classify the incoming PC; misalignment takes priority over range.
  // NOTE: the default assignment first means every path assigns req_err,
  // so no latch is inferred.
  always_comb begin
    req_err = ERR_NONE;
    if (req_pc[1:0] != 2'b00) begin
      req_err = ERR_MISALIGN;
    end else if ({1'b0, req_pc} >= PC_LIMIT) begin
      req_err = ERR_RANGE;
    end
  end

  assign req_ready = (state == FETCH) && (!resp_valid || resp_ready);
  assign accept    = req_valid && req_ready;
  assign ld_oob    = {1'b0, ld_addr} >= LD_LIMIT;
  assign mem_we    = reset_n && (state == LOAD) && ld_valid && !ld_oob;
  assign mem_re    = accept && (req_err == ERR_NONE);

  inst_mem_array #(
    .DEPTH_BYTES (DEPTH_BYTES)
  ) u_array (
    .clk     (clk),
    .reset_n (reset_n),
    .we      (mem_we),
    .waddr   (ld_addr[AW-1:0]),
    .wdata   (ld_data),
    .wbe     (ld_be),
    .re      (mem_re),
    .raddr   (req_pc[AW+1:2]),
    .rdata   (mem_rdata)
  );

  // Mode FSM: drain any pending response before entering LOAD.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state   <= FETCH;
      in_load <= 1'b0;
    end else begin
      case (state)
        FETCH: begin
          if (load_mode) begin
            if (accept || (resp_valid && !resp_ready)) begin
              state <= DRAIN;
            end else begin
              state   <= LOAD;
              in_load <= 1'b1;
            end
          end
        end
        DRAIN: begin
          if (!load_mode) begin
            state <= FETCH;
          end else if (!resp_valid || resp_ready) begin
            state   <= LOAD;
            in_load <= 1'b1;
          end
        end
        LOAD: begin
          if (!load_mode) begin
            state   <= FETCH;
            in_load <= 1'b0;
          end
        end
        default: begin
          state   <= FETCH;
          in_load <= 1'b0;
        end
      endcase
    end
  end

  // Response pipeline register: load on accept, clear when consumed.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      resp_valid <= 1'b0;
      resp_err_q <= ERR_NONE;
    end else if (accept) begin
      resp_valid <= 1'b1;
      resp_err_q <= req_err;
    end else if (resp_ready) begin
      resp_valid <= 1'b0;
    end
  end

  assign resp_err   = resp_err_q;
  assign resp_instr = (resp_err_q == ERR_NONE) ? mem_rdata : NOP_INSTR;

  // Single-cycle flag for a load write that fell outside the memory.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      ld_err <= 1'b0;
    end else begin
      ld_err <= (state == LOAD) && ld_valid && ld_oob;
    end
  end

`ifdef INST_MEM_PERF_CNT_EN
  // Saturating counters of accepted fetches and of error responses issued;
  // accepts only happen in FETCH so LOAD never counts.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      fetch_cnt <= '0;
      err_cnt   <= '0;
    end else if (accept) begin
      if (fetch_cnt != '1) begin
        fetch_cnt <= fetch_cnt + 32'd1;
      end
      if ((req_err != ERR_NONE) && (err_cnt != '1)) begin
        err_cnt <= err_cnt + 16'd1;
      end
    end
  end
`else
  // Counters are not built in this configuration.
`endif

endmodule

// File: tb/tb_inst_mem_fetch.sv
// Directed bench for inst_mem_fetch (default 1 KiB configuration).
module tb_inst_mem_fetch;

  localparam int ADDR_W = 32;

  logic              clk = 1'b0;
  logic              reset_n;
  logic              req_valid;
  logic              req_ready;
  logic [ADDR_W-1:0] req_pc;
  logic              resp_valid;
  logic              resp_ready;
  logic [31:0]       resp_instr;
  logic [1:0]        resp_err;
  logic              load_mode;
  logic              ld_valid;
  logic [ADDR_W-3:0] ld_addr;
  logic [31:0]       ld_data;
  logic [3:0]        ld_be;
  logic              ld_err;
  logic              in_load;
`ifdef INST_MEM_PERF_CNT_EN
  logic [31:0]       fetch_cnt;
  logic [15:0]       err_cnt;
`endif

  int checks = 0;
  int errors = 0;

  inst_mem_fetch #(
    .ADDR_W      (ADDR_W),
    .DEPTH_BYTES (1024)
  ) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_pc     (req_pc),
    .resp_valid (resp_valid),
    .resp_ready (resp_ready),
    .resp_instr (resp_instr),
    .resp_err   (resp_err),
    .load_mode  (load_mode),
    .ld_valid   (ld_valid),
    .ld_addr    (ld_addr),
    .ld_data    (ld_data),
    .ld_be      (ld_be),
    .ld_err     (ld_err),
    .in_load    (in_load)
`ifdef INST_MEM_PERF_CNT_EN
    ,
    .fetch_cnt  (fetch_cnt),
    .err_cnt    (err_cnt)
`endif
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Advance one clock; inputs change and outputs are sampled 1 ns after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load_write(input logic [29:0] addr, input logic [31:0] data, input logic [3:0] be);
    ld_valid = 1'b1;
    ld_addr  = addr;
    ld_data  = data;
    ld_be    = be;
    tick();
    ld_valid = 1'b0;
  endtask

  // Single fetch with resp_ready=1; checks the response one cycle later.
  task automatic fetch_one(input string tag, input logic [31:0] pc,
                           input logic [31:0] exp_instr, input logic [1:0] exp_err);
    req_valid = 1'b1;
    req_pc    = pc;
    check({tag, "_ready"}, {31'd0, req_ready}, 32'd1);
    tick();
    req_valid = 1'b0;
    check({tag, "_valid"}, {31'd0, resp_valid}, 32'd1);
    check({tag, "_instr"}, resp_instr, exp_instr);
    check({tag, "_err"}, {30'd0, resp_err}, {30'd0, exp_err});
  endtask

  typedef struct {
    logic [31:0] pc;
    logic [31:0] instr;
    logic [1:0]  err;
  } vec_t;

  vec_t stream_vecs [3];
  vec_t err_vecs [5];

  initial begin
    stream_vecs[0] = '{32'h0000_0000, 32'h0094_0333, 2'b00};
    stream_vecs[1] = '{32'h0000_0004, 32'h11BB_33DD, 2'b00};
    stream_vecs[2] = '{32'h0000_0008, 32'hDEAD_BEEF, 2'b00};

    err_vecs[0] = '{32'h0000_0002, 32'h0000_0013, 2'b01};
    err_vecs[1] = '{32'h0000_0400, 32'h0000_0013, 2'b10};
    err_vecs[2] = '{32'h0000_0401, 32'h0000_0013, 2'b01};
    err_vecs[3] = '{32'h0000_03FC, 32'h0BAD_F00D, 2'b00};
    err_vecs[4] = '{32'hFFFF_FFFC, 32'h0000_0013, 2'b10};

    reset_n    = 1'b0;
    req_valid  = 1'b0;
    req_pc     = '0;
    resp_ready = 1'b1;
    load_mode  = 1'b0;
    ld_valid   = 1'b0;
    ld_addr    = '0;
    ld_data    = '0;
    ld_be      = '0;
    tick();
    tick();

    // Reset state
    check("rst_resp_valid", {31'd0, resp_valid}, 32'd0);
    check("rst_resp_instr", resp_instr, 32'd0);
    check("rst_resp_err", {30'd0, resp_err}, 32'd0);
    check("rst_ld_err", {31'd0, ld_err}, 32'd0);
    check("rst_in_load", {31'd0, in_load}, 32'd0);
    reset_n = 1'b1;
    tick();
    check("rst_req_ready", {31'd0, req_ready}, 32'd1);

    // Enter LOAD directly (nothing pending) and program the memory
    load_mode = 1'b1;
    tick();
    check("load_in_load", {31'd0, in_load}, 32'd1);
    check("load_req_ready", {31'd0, req_ready}, 32'd0);
    load_write(30'd0,   32'h0094_0333, 4'b1111);
    load_write(30'd1,   32'h1122_3344, 4'b1111);
    load_write(30'd1,   32'hAABB_CCDD, 4'b0101);
    load_write(30'd2,   32'hDEAD_BEEF, 4'b1111);
    load_write(30'd255, 32'h0BAD_F00D, 4'b1111);
    check("ld_err_inrange", {31'd0, ld_err}, 32'd0);
    load_write(30'd256, 32'hFFFF_FFFF, 4'b1111);
    check("ld_err_pulse", {31'd0, ld_err}, 32'd1);
    tick();
    check("ld_err_clear", {31'd0, ld_err}, 32'd0);

    // Back to FETCH
    load_mode = 1'b0;
    tick();
    check("fetch_in_load", {31'd0, in_load}, 32'd0);

    // Streaming: back-to-back requests, one response per cycle
    req_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      req_pc = stream_vecs[i].pc;
      check($sformatf("stream%0d_ready", i), {31'd0, req_ready}, 32'd1);
      tick();
      check($sformatf("stream%0d_valid", i), {31'd0, resp_valid}, 32'd1);
      check($sformatf("stream%0d_instr", i), resp_instr, stream_vecs[i].instr);
      check($sformatf("stream%0d_err", i), {30'd0, resp_err}, {30'd0, stream_vecs[i].err});
    end
    req_valid = 1'b0;
    tick();
    check("stream_drain_valid", {31'd0, resp_valid}, 32'd0);

    // Error classification and last-word boundary
    for (int i = 0; i < 5; i++) begin
      fetch_one($sformatf("errv%0d", i), err_vecs[i].pc, err_vecs[i].instr, err_vecs[i].err);
    end
    tick();

    // Backpressure: response held for 3 cycles, then next request accepted
    resp_ready = 1'b0;
    req_valid  = 1'b1;
    req_pc     = 32'h0;
    tick();
    req_pc = 32'h4;
    for (int i = 0; i < 3; i++) begin
      check($sformatf("bp%0d_ready", i), {31'd0, req_ready}, 32'd0);
      check($sformatf("bp%0d_valid", i), {31'd0, resp_valid}, 32'd1);
      check($sformatf("bp%0d_instr", i), resp_instr, 32'h0094_0333);
      check($sformatf("bp%0d_err", i), {30'd0, resp_err}, 32'd0);
      tick();
    end
    resp_ready = 1'b1;
    #1;
    check("bp_release_ready", {31'd0, req_ready}, 32'd1);
    tick();
    req_valid = 1'b0;
    check("bp_next_valid", {31'd0, resp_valid}, 32'd1);
    check("bp_next_instr", resp_instr, 32'h11BB_33DD);
    tick();
    check("bp_done_valid", {31'd0, resp_valid}, 32'd0);

    // Load strobes outside LOAD must be ignored
    load_write(30'd0, 32'h0000_0000, 4'b1111);
    check("ign_ld_err", {31'd0, ld_err}, 32'd0);
    fetch_one("ign_fetch", 32'h0, 32'h0094_0333, 2'b00);
    tick();

    // Mode change with a stalled response: FETCH -> DRAIN -> LOAD
    resp_ready = 1'b0;
    req_valid  = 1'b1;
    req_pc     = 32'h8;
    tick();
    req_valid = 1'b0;
    load_mode = 1'b1;
    tick();
    check("drain_in_load", {31'd0, in_load}, 32'd0);
    check("drain_valid", {31'd0, resp_valid}, 32'd1);
    check("drain_ready", {31'd0, req_ready}, 32'd0);
    resp_ready = 1'b1;
    #1;
    check("drain_ready_rr", {31'd0, req_ready}, 32'd0);
    check("drain_instr", resp_instr, 32'hDEAD_BEEF);
    tick();
    check("drain_done_valid", {31'd0, resp_valid}, 32'd0);
    check("drain_to_load", {31'd0, in_load}, 32'd1);

    // load_mode dropped during DRAIN: back to FETCH, response kept
    load_mode = 1'b0;
    tick();
    resp_ready = 1'b0;
    req_valid  = 1'b1;
    req_pc     = 32'h4;
    tick();
    req_valid = 1'b0;
    load_mode = 1'b1;
    tick();
    load_mode = 1'b0;
    tick();
    check("abort_in_load", {31'd0, in_load}, 32'd0);
    check("abort_valid", {31'd0, resp_valid}, 32'd1);
    check("abort_instr", resp_instr, 32'h11BB_33DD);
    check("abort_ready", {31'd0, req_ready}, 32'd0);
    resp_ready = 1'b1;
    tick();
    check("abort_done_valid", {31'd0, resp_valid}, 32'd0);

    // Reset in LOAD with a write on the reset cycle
    load_mode = 1'b1;
    tick();
    check("rl_in_load", {31'd0, in_load}, 32'd1);
    reset_n  = 1'b0;
    ld_valid = 1'b1;
    ld_addr  = 30'd0;
    ld_data  = 32'h0000_0000;
    ld_be    = 4'b1111;
    tick();
    ld_valid  = 1'b0;
    load_mode = 1'b0;
    check("rl_in_load_rst", {31'd0, in_load}, 32'd0);
    check("rl_valid_rst", {31'd0, resp_valid}, 32'd0);
    reset_n = 1'b1;
    tick();
    fetch_one("rl_retained", 32'h0, 32'h0094_0333, 2'b00);
    fetch_one("rl_retained2", 32'h3FC, 32'h0BAD_F00D, 2'b00);
    tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
